multi_lane_shifter: RTL and testbench

- Bank of LANES independent WIDTH-bit shift lanes, e.g. sprite position strips for player and enemies.
- Each lane has its own op: hold, shift or rotate in either direction, plus parallel load.
- Shifts advance only on an internal programmable tick, so game speed is set by a register, not by the clock.
- A sticky overlap detector flags when lane 0 shares a set bit with any other lane; this is the collision event for the game FSM.

---
 rtl/multi_lane_shifter_pkg.sv | 17 +
 rtl/multi_lane_shifter_tick_divider.sv | 46 ++++
 rtl/multi_lane_shifter.sv | 152 +++++++++++++++
 tb/tb_multi_lane_shifter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_lane_shifter_pkg.sv
// +----------------------------------------------------------------------+
// | mls_pkg : op codes shared by the multi-lane shifter                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mls_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd1;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd2;
  localparam logic [OP_W-1:0] OP_ROL  = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd4;
endpackage

`default_nettype wire

// File: rtl/multi_lane_shifter_tick_divider.sv
// +----------------------------------------------------------------------+
// | tick_divider : registered one-cycle tick every period+1 enabled cycles|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             clr,
  input  logic             tick_en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  // >= compare lets a shortened period fire at once instead of wrapping
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (tick_en) begin
      if (r_cnt >= period) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/multi_lane_shifter.sv
// +----------------------------------------------------------------------+
// | multi_lane_shifter : tick-paced shift/rotate lanes with sticky       |
// | lane-0 overlap flag; MLS_STEP_COUNT_EN adds a saturating step_cnt.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module multi_lane_shifter
  import mls_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter int               LANES     = 2,
  parameter int               DIV_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   preset,
  input  logic                   clr,
  input  logic                   tick_en,
  input  logic [DIV_W-1:0]       period,
  input  logic [OP_W*LANES-1:0]  op,
  input  logic [LANES-1:0]       serial_in,
  input  logic [LANES-1:0]       load,
  input  logic [WIDTH*LANES-1:0] load_val,
  output logic [WIDTH*LANES-1:0] q,
  output logic [LANES-1:0]       serial_out,
  output logic                   tick,
  output logic                   overlap
`ifdef MLS_STEP_COUNT_EN
  ,
  output logic [15:0]            step_cnt
`endif
);

  logic w_tick;
  logic w_hit;
  logic r_overlap;
`ifdef MLS_STEP_COUNT_EN
  logic [LANES-1:0] w_shifted;
  logic [15:0]      r_step;
`endif

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_tick_divider (
    .clk     (clk),
    .preset  (preset),
    .clr     (clr),
    .tick_en (tick_en),
    .period  (period),
    .tick    (w_tick)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [OP_W-1:0]  w_op;
    logic [WIDTH-1:0] w_next;
    logic             w_out;
    logic             w_act;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;

    assign w_op = op[OP_W*k +: OP_W];

    always_comb begin
      w_next = r_q;
      w_out  = r_sout;
      w_act  = 1'b0;
      case (w_op)
        OP_SHL: begin
          w_next = {r_q[WIDTH-2:0], serial_in[k]};
          w_out  = r_q[WIDTH-1];
          w_act  = 1'b1;
        end
        OP_SHR: begin
          w_next = {serial_in[k], r_q[WIDTH-1:1]};
          w_out  = r_q[0];
          w_act  = 1'b1;
        end
        OP_ROL: begin
          w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_out  = r_q[WIDTH-1];
          w_act  = 1'b1;
        end
        OP_ROR: begin
          w_next = {r_q[0], r_q[WIDTH-1:1]};
          w_out  = r_q[0];
          w_act  = 1'b1;
        end
        default: ;
      endcase
    end

    // clr beats load, load beats the tick-gated op (that tick's shift is lost)
    always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
        r_q    <= RESET_VAL;
        r_sout <= 1'b0;
      end else if (clr) begin
        r_q    <= RESET_VAL;
        r_sout <= 1'b0;
      end else if (load[k]) begin
        r_q <= load_val[WIDTH*k +: WIDTH];
      end else if (w_tick && w_act) begin
        r_q    <= w_next;
        r_sout <= w_out;
      end
    end

    assign q[WIDTH*k +: WIDTH] = r_q;
    assign serial_out[k]       = r_sout;
`ifdef MLS_STEP_COUNT_EN
    assign w_shifted[k] = w_tick & w_act & ~load[k];
`endif
  end

  always_comb begin
    w_hit = 1'b0;
    for (int k = 1; k < LANES; k++) begin
      w_hit = w_hit | (|(q[0 +: WIDTH] & q[WIDTH*k +: WIDTH]));
    end
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_overlap <= 1'b0;
    end else if (clr) begin
      r_overlap <= 1'b0;
    end else begin
      r_overlap <= r_overlap | w_hit;
    end
  end

  assign tick    = w_tick;
  assign overlap = r_overlap;

`ifdef MLS_STEP_COUNT_EN
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_step <= '0;
    end else if (clr) begin
      r_step <= '0;
    end else if ((|w_shifted) && (r_step != 16'hFFFF)) begin
      r_step <= r_step + 1'b1;
    end
  end

  assign step_cnt = r_step;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_lane_shifter.sv
// +----------------------------------------------------------------------+
// | tb_multi_lane_shifter : directed self-checking bench with scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multi_lane_shifter;
  import mls_pkg::*;

  localparam int WIDTH = 5;
  localparam int LANES = 2;
  localparam int DIV_W = 16;
  localparam logic [WIDTH-1:0] RV = 5'b00001;
  localparam logic [WIDTH*LANES-1:0] QRST = {RV, RV};

  logic                   clk;
  logic                   preset;
  logic                   clr;
  logic                   tick_en;
  logic [DIV_W-1:0]       period;
  logic [OP_W*LANES-1:0]  op;
  logic [LANES-1:0]       serial_in;
  logic [LANES-1:0]       load;
  logic [WIDTH*LANES-1:0] load_val;
  logic [WIDTH*LANES-1:0] q;
  logic [LANES-1:0]       serial_out;
  logic                   tick;
  logic                   overlap;
`ifdef MLS_STEP_COUNT_EN
  logic [15:0]            step_cnt;
`endif

  typedef struct packed {
    logic [WIDTH*LANES-1:0] q;
    logic [LANES-1:0]       so;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  multi_lane_shifter #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .DIV_W     (DIV_W),
    .RESET_VAL (RV)
  ) dut (
    .clk        (clk),
    .preset     (preset),
    .clr        (clr),
    .tick_en    (tick_en),
    .period     (period),
    .op         (op),
    .serial_in  (serial_in),
    .load       (load),
    .load_val   (load_val),
    .q          (q),
    .serial_out (serial_out),
    .tick       (tick),
    .overlap    (overlap)
`ifdef MLS_STEP_COUNT_EN
    ,
    .step_cnt   (step_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed q %0h", tag, q);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(q), 32'(e.q));
      chk({tag, "_so"}, 32'(serial_out), 32'(e.so));
    end
  endtask

  initial begin
    preset = 1'b1; clr = 1'b0; tick_en = 1'b0; period = '0; op = '0;
    serial_in = '0; load = '0; load_val = '0;

    // Reset state while preset is held, then overlap one cycle after release
    #2;
    chk("rst_q", 32'(q), 32'(QRST));
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_so", 32'(serial_out), 32'd0);
    chk("rst_ovl", 32'(overlap), 32'd0);
    #10 preset = 1'b0;
    step();
    chk("rst_ovl_rise", 32'(overlap), 32'd1);

    // Shift left/right with period=2
    clr = 1'b1;
    step();
    chk("clr_q", 32'(q), 32'(QRST));
    chk("clr_ovl", 32'(overlap), 32'd0);
    chk("clr_tick", 32'(tick), 32'd0);
    clr = 1'b0; load = 2'b11; load_val = {5'b00011, 5'b10000};
    period = 16'd2; op = {OP_SHL, OP_SHR}; serial_in = 2'b00;
    step();
    chk("ld_q", 32'(q), 32'({5'b00011, 5'b10000}));
    load = 2'b00; tick_en = 1'b1;
    step(); chk("shf_t0a", 32'(tick), 32'd0);
    step(); chk("shf_t0b", 32'(tick), 32'd0);
    step(); chk("shf_t1", 32'(tick), 32'd1);
    sb.push_back({5'b00110, 5'b01000, 2'b00});
    step(); pop_check("shift1");
    chk("shf_t1_low", 32'(tick), 32'd0);
    step(); chk("shf_t2a", 32'(tick), 32'd0);
    step(); chk("shf_t2", 32'(tick), 32'd1);
    sb.push_back({5'b01100, 5'b00100, 2'b00});
    step(); pop_check("shift2");
    tick_en = 1'b0;
    step(); chk("shf_ovl", 32'(overlap), 32'd1);

    // Rotate left lane 0 every cycle
    op = '0; clr = 1'b1;
    step();
    clr = 1'b0; load = 2'b11; load_val = {5'b00000, 5'b10001};
    step();
    load = 2'b00; op = {OP_HOLD, OP_ROL}; period = 16'd0; tick_en = 1'b1;
    step(); chk("rol_tick", 32'(tick), 32'd1);
    sb.push_back({5'b00000, 5'b00011, 2'b01});
    sb.push_back({5'b00000, 5'b00110, 2'b00});
    sb.push_back({5'b00000, 5'b01100, 2'b00});
    sb.push_back({5'b00000, 5'b11000, 2'b00});
    sb.push_back({5'b00000, 5'b10001, 2'b01});
    for (int i = 0; i < 5; i++) begin
      step(); pop_check($sformatf("rol%0d", i));
    end
    op = '0; tick_en = 1'b0;
    step();

    // Priority: clr beats load and tick, then load beats tick
    op = {OP_SHR, OP_SHL}; period = 16'd0; tick_en = 1'b1;
    step(); chk("pri_tick", 32'(tick), 32'd1);
    clr = 1'b1; load = 2'b11; load_val = {5'b10010, 5'b00100};
    step();
    chk("pri_clr_q", 32'(q), 32'(QRST));
    chk("pri_clr_ovl", 32'(overlap), 32'd0);
    chk("pri_clr_tick", 32'(tick), 32'd0);
    clr = 1'b0; load = 2'b00;
    step(); chk("pri_tick2", 32'(tick), 32'd1);
    load = 2'b11;
    step(); chk("pri_load_q", 32'(q), 32'({5'b10010, 5'b00100}));
    load = 2'b00; op = '0; tick_en = 1'b0;
    step();

    // Period change mid-count and tick_en freeze
    clr = 1'b1;
    step();
    clr = 1'b0; load = 2'b11; load_val = '0; op = {OP_HOLD, OP_SHL};
    serial_in = 2'b01; period = 16'd10;
    step();
    load = 2'b00; tick_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(); chk($sformatf("per_cnt%0d", i + 1), 32'(tick), 32'd0);
    end
    period = 16'd3;
    step(); chk("per_fire", 32'(tick), 32'd1);
    sb.push_back({5'b00000, 5'b00001, 2'b00});
    step(); pop_check("per_sh1");
    step(); chk("per_gap2", 32'(tick), 32'd0);
    step(); chk("per_gap3", 32'(tick), 32'd0);
    step(); chk("per_fire4", 32'(tick), 32'd1);
    sb.push_back({5'b00000, 5'b00011, 2'b00});
    tick_en = 1'b0;
    step(); pop_check("per_sh2");
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("frz_tick%0d", i), 32'(tick), 32'd0);
      chk($sformatf("frz_q%0d", i), 32'(q), 32'({5'b00000, 5'b00011}));
    end
    tick_en = 1'b1;
    step(); chk("res_gap1", 32'(tick), 32'd0);
    step(); chk("res_gap2", 32'(tick), 32'd0);
    step(); chk("res_gap3", 32'(tick), 32'd0);
    step(); chk("res_fire", 32'(tick), 32'd1);
    sb.push_back({5'b00000, 5'b00111, 2'b00});
    step(); pop_check("res_sh");

    // Asynchronous preset in the middle of shifting
    period = 16'd0;
    step();
    #2 preset = 1'b1;
    #1;
    chk("apr_q", 32'(q), 32'(QRST));
    chk("apr_tick", 32'(tick), 32'd0);
    chk("apr_so", 32'(serial_out), 32'd0);
    chk("apr_ovl", 32'(overlap), 32'd0);
    step(); chk("apr_hold_q", 32'(q), 32'(QRST));
    #2 preset = 1'b0;
    step();
    chk("apr_rel_q", 32'(q), 32'(QRST));
    chk("apr_rel_ovl", 32'(overlap), 32'd1);
    chk("apr_rel_tick", 32'(tick), 32'd1);
    tick_en = 1'b0; op = '0;
    step();

`ifdef MLS_STEP_COUNT_EN
    clr = 1'b1;
    step(); chk("stp_clr0", 32'(step_cnt), 32'd0);
    clr = 1'b0; op = {OP_SHL, OP_SHL}; period = 16'd0; tick_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    op = '0;
    step();
    step();
    tick_en = 1'b0;
    step(); chk("stp_cnt5", 32'(step_cnt), 32'd5);
    clr = 1'b1;
    step(); chk("stp_clr", 32'(step_cnt), 32'd0);
    clr = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
